// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a shared edge/center-aligned counter.
// Period, duty and mode changes are double-buffered and take effect only on a period boundary.
module pwm_multi #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PERIOD_RST = 19
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       invert,
    input  logic                      load,
    input  logic [WIDTH-1:0]          period_in,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    output logic [CHANNELS-1:0]       PWM,
    output logic [WIDTH-1:0]          counter,
    output logic                      period_end,
    output logic                      load_ack
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0]                cnt_q, cnt_d;
    dir_e                            dir_q, dir_d;
    logic                            mode_a_q, mode_a_d;
    logic [WIDTH-1:0]                period_a_q, period_a_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  duty_a_q, duty_a_d;
    logic [WIDTH-1:0]                period_s_q, period_s_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  duty_s_q, duty_s_d;
    logic                            pending_q, pending_d;
    logic [CHANNELS-1:0]             pwm_q, pwm_d;
    logic                            period_end_q, period_end_d;
    logic                            load_ack_q, load_ack_d;
    logic                            boundary;
    logic [WIDTH-1:0]                next_period;

    // Boundary: terminal count in edge mode, bottom of the down-slope in center mode.
    always_comb begin
        boundary = 1'b0;
        if (enable) begin
            if (!mode_a_q) begin
                boundary = (cnt_q == period_a_q);
            end else begin
                boundary = (period_a_q == '0) || (dir_q == DIR_DOWN && cnt_q == '0);
            end
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        mode_a_d     = mode_a_q;
        period_a_d   = period_a_q;
        duty_a_d     = duty_a_q;
        period_s_d   = period_s_q;
        duty_s_d     = duty_s_q;
        pending_d    = pending_q;
        next_period  = period_a_q;
        period_end_d = boundary;
        load_ack_d   = boundary && pending_q;

        if (boundary) begin
            mode_a_d = mode;
            if (pending_q) begin
                period_a_d  = period_s_q;
                duty_a_d    = duty_s_q;
                pending_d   = 1'b0;
                next_period = period_s_q;
            end
            dir_d = DIR_UP;
            // A center period restarts at 1 when the boundary sat on 0, so 0 is not visited twice.
            if (next_period == '0 || !mode) begin
                cnt_d = '0;
            end else begin
                cnt_d = (cnt_q == '0) ? ONE : '0;
            end
        end else if (enable) begin
            if (!mode_a_q) begin
                cnt_d = cnt_q + ONE;
            end else if (dir_q == DIR_UP) begin
                if (cnt_q == period_a_q) begin
                    cnt_d = cnt_q - ONE;
                    dir_d = DIR_DOWN;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else begin
                cnt_d = cnt_q - ONE;
            end
        end

        // A load in a boundary cycle lands in the shadow after the swap above.
        if (load) begin
            period_s_d = period_in;
            duty_s_d   = duty_in;
            pending_d  = 1'b1;
        end
    end

    always_comb begin
        pwm_d = invert;
        for (int i = 0; i < CHANNELS; i++) begin
            if (enable) begin
                pwm_d[i] = (cnt_q < duty_a_q[i]) ^ invert[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            dir_q        <= DIR_UP;
            mode_a_q     <= 1'b0;
            period_a_q   <= WIDTH'(PERIOD_RST);
            duty_a_q     <= '0;
            period_s_q   <= '0;
            duty_s_q     <= '0;
            pending_q    <= 1'b0;
            pwm_q        <= '0;
            period_end_q <= 1'b0;
            load_ack_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            mode_a_q     <= mode_a_d;
            period_a_q   <= period_a_d;
            duty_a_q     <= duty_a_d;
            period_s_q   <= period_s_d;
            duty_s_q     <= duty_s_d;
            pending_q    <= pending_d;
            pwm_q        <= pwm_d;
            period_end_q <= period_end_d;
            load_ack_q   <= load_ack_d;
        end
    end

    assign PWM        = pwm_q;
    assign counter    = cnt_q;
    assign period_end = period_end_q;
    assign load_ack   = load_ack_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed scenarios plus randomized traffic
// against a phase-based reference model.
module tb_pwm_multi;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int PR = 19;
    localparam int EW = W + CH + 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              mode;
    logic [CH-1:0]     invert;
    logic              load;
    logic [W-1:0]      period_in;
    logic [CH*W-1:0]   duty_in;
    logic [CH-1:0]     pwm;
    logic [W-1:0]      counter;
    logic              period_end;
    logic              load_ack;

    pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PERIOD_RST(PR)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .invert     (invert),
        .load       (load),
        .period_in  (period_in),
        .duty_in    (duty_in),
        .PWM        (pwm),
        .counter    (counter),
        .period_end (period_end),
        .load_ack   (load_ack)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The counter is derived from a phase index k counted from the start of the period.
    int m_k;
    bit m_mode;
    int m_per;
    int m_duty[CH];
    int s_per;
    int s_duty[CH];
    bit m_pend;

    function automatic int m_count();
        if (m_mode) return (m_k <= m_per) ? m_k : 2 * m_per - m_k;
        return m_k % (1 << W);
    endfunction

    function automatic bit m_boundary();
        if (!enable) return 1'b0;
        if (!m_mode) return m_count() == m_per;
        return (m_per == 0) || (m_k == 2 * m_per);
    endfunction

    task automatic model_reset();
        m_k    = 0;
        m_mode = 1'b0;
        m_per  = PR;
        s_per  = 0;
        m_pend = 1'b0;
        for (int i = 0; i < CH; i++) begin
            m_duty[i] = 0;
            s_duty[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_step();
        int c;
        bit b;
        bit la;
        logic [CH-1:0] pw;
        c  = m_count();
        b  = m_boundary();
        la = b && m_pend;
        for (int i = 0; i < CH; i++)
            pw[i] = enable ? ((c < m_duty[i]) ^ invert[i]) : invert[i];
        if (b) begin
            m_mode = mode;
            if (m_pend) begin
                m_per  = s_per;
                m_duty = s_duty;
                m_pend = 1'b0;
            end
            if (m_per == 0 || !m_mode) m_k = 0;
            else m_k = (c == 0) ? 1 : 0;
        end else if (enable) begin
            m_k++;
        end
        if (load) begin
            s_per = int'(period_in);
            for (int i = 0; i < CH; i++) s_duty[i] = int'(duty_in[i*W +: W]);
            m_pend = 1'b1;
        end
        exp_q.push_back({la, b, pw, W'(m_count())});
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        logic [EW-1:0] e;
        @(posedge clock);
        model_step();
        #1;
        e = exp_q.pop_front();
        check("counter",    32'(counter),    32'(e[W-1:0]));
        check("pwm",        32'(pwm),        32'(e[W+CH-1:W]));
        check("period_end", 32'(period_end), 32'(e[W+CH]));
        check("load_ack",   32'(load_ack),   32'(e[W+CH+1]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input int p, input int d0, input int d1, input int d2, input int d3);
        load      = 1'b1;
        period_in = W'(p);
        duty_in   = {W'(d3), W'(d2), W'(d1), W'(d0)};
        tick();
        load = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_counter"}, 32'(counter),    32'd0);
        check({tag, "_pwm"},     32'(pwm),        32'd0);
        check({tag, "_pe"},      32'(period_end), 32'd0);
        check({tag, "_ack"},     32'(load_ack),   32'd0);
    endtask

    task automatic wait_boundary();
        int guard;
        guard = 0;
        while (!m_boundary() && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("boundary_wait", 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        mode      = 1'b0;
        invert    = '0;
        load      = 1'b0;
        period_in = '0;
        duty_in   = '0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clock);
        reset = 1'b0;
        #1;

        // Free run from reset: 20-cycle sawtooth, outputs low.
        enable = 1'b1;
        run(45);

        // Load period 9, ch0 duty 3 in edge mode.
        do_load(9, 3, 0, 0, 0);
        run(35);

        // Center-aligned, period 4, duty 2 everywhere.
        mode = 1'b1;
        do_load(4, 2, 2, 2, 2);
        run(40);

        // Load coincident with a boundary, then a double load while pending.
        wait_boundary();
        do_load(6, 5, 1, 0, 7);
        run(20);
        do_load(3, 1, 1, 1, 1);
        run(1);
        do_load(5, 4, 2, 6, 0);
        run(30);

        // Edge mode: duty 0, duty period+1, normal duty, with mixed inversion.
        mode   = 1'b0;
        invert = 4'b1010;
        do_load(7, 0, 8, 3, 8);
        run(30);

        // Freeze mid-period, load while frozen, resume.
        run(3);
        enable = 1'b0;
        run(6);
        do_load(2, 1, 2, 3, 0);
        run(3);
        enable = 1'b1;
        run(20);

        // Period 0 in both modes.
        do_load(0, 1, 0, 1, 0);
        run(6);
        mode = 1'b1;
        run(6);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) mode = $urandom_range(0, 1);
            if ($urandom_range(0, 19) == 0) invert = CH'($urandom_range(0, (1 << CH) - 1));
            if ($urandom_range(0, 7) == 0) begin
                do_load($urandom_range(0, 10), $urandom_range(0, 12), $urandom_range(0, 12),
                        $urandom_range(0, 12), $urandom_range(0, 12));
            end else begin
                tick();
            end
        end

        // Reset mid-period with a load pending.
        enable = 1'b1;
        mode   = 1'b0;
        invert = '0;
        wait_boundary();
        run(3);
        do_load(4, 3, 3, 3, 3);
        run(2);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        run(45);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
